// File: rtl/aer_frame_builder_pkg.sv
// Shared geometry, state encoding and row type for the AER frame builder.
package aer_frame_builder_pkg;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int POLARITY = 2;
    localparam int x_width  = 3;
    localparam int y_width  = 3;

    typedef enum logic [0:0] {
        ACCUM   = 1'b0,
        READOUT = 1'b1
    } fb_state_e;

    typedef logic [COLS*POLARITY-1:0] row_data_t;

endpackage

// File: rtl/aer_frame_mem.sv
// ROWS x COLS event frame: OR-accumulating pixel write, combinational row read,
// whole-row clear. Writes must carry in-range addresses.
module aer_frame_mem #(
    parameter int ROWS     = aer_frame_builder_pkg::ROWS,
    parameter int COLS     = aer_frame_builder_pkg::COLS,
    parameter int POLARITY = aer_frame_builder_pkg::POLARITY,
    parameter int x_width  = aer_frame_builder_pkg::x_width,
    parameter int y_width  = aer_frame_builder_pkg::y_width
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [x_width-1:0]         wr_x,
    input  logic [y_width-1:0]         wr_y,
    input  logic [POLARITY-1:0]        wr_pol,
    input  logic                       clr_en,
    input  logic [x_width-1:0]         clr_x,
    input  logic [x_width-1:0]         rd_x,
    output logic [COLS*POLARITY-1:0]   rd_data
);
    import aer_frame_builder_pkg::*;

    logic [COLS*POLARITY-1:0] mem_r [ROWS];
    logic [COLS*POLARITY-1:0] wr_mask_s;

    // Place the polarity bits at the addressed column of an otherwise empty row.
    always_comb begin
        wr_mask_s = {(COLS*POLARITY){1'b0}};
        for (int c = 0; c < COLS; c++) begin
            if (wr_y == c[y_width-1:0]) begin
                wr_mask_s[c*POLARITY +: POLARITY] = wr_pol;
            end else begin
                wr_mask_s[c*POLARITY +: POLARITY] = {POLARITY{1'b0}};
            end
        end
    end

    // Frame storage; a clear wins over a write to the same row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_r[r] <= {(COLS*POLARITY){1'b0}};
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (clr_en && (clr_x == r[x_width-1:0])) begin
                    mem_r[r] <= {(COLS*POLARITY){1'b0}};
                end else if (we && (wr_x == r[x_width-1:0])) begin
                    mem_r[r] <= mem_r[r] | wr_mask_s;
                end else begin
                    mem_r[r] <= mem_r[r];
                end
            end
        end
    end

    assign rd_data = mem_r[rd_x];

endmodule

// File: rtl/aer_frame_builder.sv
// Collects address events into a frame and, on trigger, streams it out row by
// row while clearing each row as it is consumed.
module aer_frame_builder #(
    parameter int ROWS     = aer_frame_builder_pkg::ROWS,
    parameter int COLS     = aer_frame_builder_pkg::COLS,
    parameter int POLARITY = aer_frame_builder_pkg::POLARITY,
    parameter int x_width  = aer_frame_builder_pkg::x_width,
    parameter int y_width  = aer_frame_builder_pkg::y_width
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       ev_valid_i,
    output logic                       ev_ready_o,
    input  logic [x_width-1:0]         ev_x_i,
    input  logic [y_width-1:0]         ev_y_i,
    input  logic [POLARITY-1:0]        ev_pol_i,
    input  logic                       frame_trig_i,
    output logic                       row_valid_o,
    input  logic                       row_ready_i,
    output logic [x_width-1:0]         row_idx_o,
    output logic [COLS*POLARITY-1:0]   row_data_o,
    output logic                       frame_done_o,
    output logic                       ev_drop_o,
    output logic                       trig_miss_o
);
    import aer_frame_builder_pkg::*;

    // One extra bit so non-power-of-two geometries compare correctly.
    localparam logic [x_width:0]   ROWS_L   = ROWS[x_width:0];
    localparam logic [y_width:0]   COLS_L   = COLS[y_width:0];
    localparam int                 LAST_I   = ROWS - 1;
    localparam logic [x_width-1:0] LAST_ROW = LAST_I[x_width-1:0];

    fb_state_e                state_r;
    logic [x_width-1:0]       row_ptr_r;
    logic                     frame_done_r;
    logic                     ev_drop_r;
    logic                     trig_miss_r;
    logic                     ev_accept_s;
    logic                     addr_ok_s;
    logic                     row_fire_s;
    logic                     last_row_s;
    logic [COLS*POLARITY-1:0] rd_data_s;

    // Handshake qualifiers and address range check.
    always_comb begin
        ev_accept_s = ev_valid_i && (state_r == ACCUM);
        addr_ok_s   = ({1'b0, ev_x_i} < ROWS_L) && ({1'b0, ev_y_i} < COLS_L);
        row_fire_s  = (state_r == READOUT) && row_ready_i;
        last_row_s  = (row_ptr_r == LAST_ROW);
    end

    aer_frame_mem #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .POLARITY (POLARITY),
        .x_width  (x_width),
        .y_width  (y_width)
    ) u_mem (
        .clk     (clk_i),
        .rst_n   (reset_i),
        .we      (ev_accept_s && addr_ok_s),
        .wr_x    (ev_x_i),
        .wr_y    (ev_y_i),
        .wr_pol  (ev_pol_i),
        .clr_en  (row_fire_s),
        .clr_x   (row_ptr_r),
        .rd_x    (row_ptr_r),
        .rd_data (rd_data_s)
    );

    // Accumulate/readout sequencing and the registered status pulses.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r      <= ACCUM;
            row_ptr_r    <= {x_width{1'b0}};
            frame_done_r <= 1'b0;
            ev_drop_r    <= 1'b0;
            trig_miss_r  <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            ev_drop_r    <= ev_accept_s && !addr_ok_s;
            trig_miss_r  <= 1'b0;
            case (state_r)
                ACCUM: begin
                    row_ptr_r <= {x_width{1'b0}};
                    if (frame_trig_i) begin
                        state_r <= READOUT;
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                READOUT: begin
                    trig_miss_r <= frame_trig_i;
                    if (row_ready_i && last_row_s) begin
                        row_ptr_r    <= {x_width{1'b0}};
                        state_r      <= ACCUM;
                        frame_done_r <= 1'b1;
                    end else if (row_ready_i) begin
                        row_ptr_r <= row_ptr_r + {{(x_width-1){1'b0}}, 1'b1};
                        state_r   <= READOUT;
                    end else begin
                        row_ptr_r <= row_ptr_r;
                        state_r   <= READOUT;
                    end
                end
                default: begin
                    state_r   <= ACCUM;
                    row_ptr_r <= {x_width{1'b0}};
                end
            endcase
        end
    end

    assign ev_ready_o   = (state_r == ACCUM);
    assign row_valid_o  = (state_r == READOUT);
    assign row_idx_o    = row_ptr_r;
    assign row_data_o   = (state_r == READOUT) ? rd_data_s : {(COLS*POLARITY){1'b0}};
    assign frame_done_o = frame_done_r;
    assign ev_drop_o    = ev_drop_r;
    assign trig_miss_o  = trig_miss_r;

endmodule

// File: tb/tb_aer_frame_builder.sv
// Directed bench for aer_frame_builder: 8x8 default instance plus a 6-row
// instance for out-of-range address handling.
module tb_aer_frame_builder;
    import aer_frame_builder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ev_valid, ev_ready, frame_trig, row_valid, row_ready;
    logic [2:0] ev_x, ev_y, row_idx;
    logic [1:0] ev_pol;
    row_data_t  row_data;
    logic       frame_done, ev_drop, trig_miss;

    logic       ev_valid6, ev_ready6, frame_trig6, row_valid6, row_ready6;
    logic [2:0] ev_x6, ev_y6, row_idx6;
    logic [1:0] ev_pol6;
    row_data_t  row_data6;
    logic       frame_done6, ev_drop6, trig_miss6;

    int checks = 0;
    int errors = 0;

    aer_frame_builder dut (
        .clk_i(clk), .reset_i(rst_n), .ev_valid_i(ev_valid), .ev_ready_o(ev_ready),
        .ev_x_i(ev_x), .ev_y_i(ev_y), .ev_pol_i(ev_pol), .frame_trig_i(frame_trig),
        .row_valid_o(row_valid), .row_ready_i(row_ready), .row_idx_o(row_idx),
        .row_data_o(row_data), .frame_done_o(frame_done), .ev_drop_o(ev_drop),
        .trig_miss_o(trig_miss)
    );

    aer_frame_builder #(.ROWS(6)) dut6 (
        .clk_i(clk), .reset_i(rst_n), .ev_valid_i(ev_valid6), .ev_ready_o(ev_ready6),
        .ev_x_i(ev_x6), .ev_y_i(ev_y6), .ev_pol_i(ev_pol6), .frame_trig_i(frame_trig6),
        .row_valid_o(row_valid6), .row_ready_i(row_ready6), .row_idx_o(row_idx6),
        .row_data_o(row_data6), .frame_done_o(frame_done6), .ev_drop_o(ev_drop6),
        .trig_miss_o(trig_miss6)
    );

    typedef struct {
        logic [2:0][2:0] ex;
        logic [2:0][2:0] ey;
        logic [2:0][1:0] ep;
        logic [2:0]      exp_idx;
        logic [15:0]     exp_data;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_event(input logic [2:0] x, input logic [2:0] y, input logic [1:0] p);
        ev_valid = 1'b1;
        ev_x     = x;
        ev_y     = y;
        ev_pol   = p;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic trigger();
        frame_trig = 1'b1;
        step();
        frame_trig = 1'b0;
    endtask

    // Reads a whole frame; one row may be non-zero. bp throttles ready 1,0,0,...
    // and miss_at pulses the trigger while that row is presented.
    task automatic do_readout(input logic [2:0] exp_idx, input logic [15:0] exp_data,
                              input int miss_at, input bit bp);
        int ptr = 0;
        int cyc = 0;
        bit trig_prev = 1'b0;
        bit miss_used = 1'b0;
        logic [15:0] exp_row;
        while (ptr < 8 && cyc < 64) begin
            row_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            frame_trig = (ptr == miss_at) && !miss_used;
            if (frame_trig) miss_used = 1'b1;
            #1;
            exp_row = (ptr == int'(exp_idx)) ? exp_data : 16'h0000;
            chk("row_valid", row_valid, 1);
            chk("row_idx", row_idx, ptr);
            chk("row_data", row_data, exp_row);
            chk("ev_ready_in_readout", ev_ready, 0);
            chk("frame_done_in_readout", frame_done, 0);
            chk("trig_miss", trig_miss, trig_prev);
            trig_prev = frame_trig;
            if (row_ready) ptr++;
            cyc++;
            step();
        end
        if (ptr < 8) chk("readout_timeout", ptr, 8);
        frame_trig = 1'b0;
        row_ready  = 1'b0;
        #1;
        chk("frame_done_pulse", frame_done, 1);
        chk("ev_ready_after_frame", ev_ready, 1);
        chk("row_valid_after_frame", row_valid, 0);
        chk("trig_miss_end", trig_miss, trig_prev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0].ex = {3'd2, 3'd2, 3'd2}; vecs[0].ey = {3'd5, 3'd5, 3'd5};
        vecs[0].ep = {2'b01, 2'b00, 2'b01}; vecs[0].exp_idx = 3'd2; vecs[0].exp_data = 16'h0400;
        vecs[1].ex = {3'd3, 3'd3, 3'd3}; vecs[1].ey = {3'd7, 3'd1, 3'd1};
        vecs[1].ep = {2'b10, 2'b10, 2'b01}; vecs[1].exp_idx = 3'd3; vecs[1].exp_data = 16'h800C;
        vecs[2].ex = {3'd5, 3'd5, 3'd5}; vecs[2].ey = {3'd0, 3'd0, 3'd0};
        vecs[2].ep = {2'b01, 2'b10, 2'b00}; vecs[2].exp_idx = 3'd5; vecs[2].exp_data = 16'h0003;
        vecs[3].ex = {3'd0, 3'd0, 3'd0}; vecs[3].ey = {3'd3, 3'd3, 3'd3};
        vecs[3].ep = {2'b10, 2'b10, 2'b10}; vecs[3].exp_idx = 3'd0; vecs[3].exp_data = 16'h0080;

        rst_n = 1'b0;
        ev_valid = 1'b0; ev_x = 3'd0; ev_y = 3'd0; ev_pol = 2'b00;
        frame_trig = 1'b0; row_ready = 1'b0;
        ev_valid6 = 1'b0; ev_x6 = 3'd0; ev_y6 = 3'd0; ev_pol6 = 2'b00;
        frame_trig6 = 1'b0; row_ready6 = 1'b0;

        // Reset state
        #12;
        chk("rst_ev_ready", ev_ready, 1);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ev_drop", ev_drop, 0);
        chk("rst_trig_miss", trig_miss, 0);
        chk("rst6_ev_ready", ev_ready6, 1);
        chk("rst6_row_valid", row_valid6, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_ev_ready", ev_ready, 1);
        chk("idle_row_valid", row_valid, 0);

        // Table: events, trigger, full readout with ready held high
        for (int v = 0; v < 4; v++) begin
            for (int e = 0; e < 3; e++) begin
                send_event(vecs[v].ex[e], vecs[v].ey[e], vecs[v].ep[e]);
            end
            chk("ev_drop_in_range", ev_drop, 0);
            trigger();
            do_readout(vecs[v].exp_idx, vecs[v].exp_data, 8, 1'b0);
        end

        // Trigger in the frame_done cycle: everything was cleared on read
        trigger();
        do_readout(3'd0, 16'h0000, 8, 1'b0);

        // Back-pressure with an event held during readout
        send_event(3'd1, 3'd4, 2'b01);
        trigger();
        ev_valid = 1'b1; ev_x = 3'd6; ev_y = 3'd2; ev_pol = 2'b10;
        do_readout(3'd1, 16'h0100, 8, 1'b1);
        step();
        ev_valid = 1'b0;
        trigger();
        do_readout(3'd6, 16'h0020, 8, 1'b0);

        // Event coincident with trigger, plus a missed trigger at row 4
        ev_valid = 1'b1; ev_x = 3'd7; ev_y = 3'd7; ev_pol = 2'b01;
        frame_trig = 1'b1;
        step();
        ev_valid = 1'b0;
        frame_trig = 1'b0;
        do_readout(3'd7, 16'h4000, 4, 1'b0);

        // Reset during readout of row 3
        send_event(3'd3, 3'd3, 2'b11);
        trigger();
        row_ready = 1'b1;
        step();
        step();
        step();
        chk("mid_row_idx", row_idx, 3);
        chk("mid_row_data", row_data, 16'h00C0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row_valid", row_valid, 0);
        chk("mid_rst_ev_ready", ev_ready, 1);
        chk("mid_rst_row_data", row_data, 0);
        #2;
        rst_n = 1'b1;
        row_ready = 1'b0;
        step();
        trigger();
        do_readout(3'd0, 16'h0000, 8, 1'b0);

        // Six-row build: x=6 is out of range
        ev_valid6 = 1'b1; ev_x6 = 3'd6; ev_y6 = 3'd1; ev_pol6 = 2'b01;
        step();
        ev_valid6 = 1'b0;
        chk("drop6_pulse", ev_drop6, 1);
        step();
        chk("drop6_one_cycle", ev_drop6, 0);
        ev_valid6 = 1'b1; ev_x6 = 3'd5; ev_y6 = 3'd2; ev_pol6 = 2'b10;
        step();
        ev_valid6 = 1'b0;
        chk("drop6_in_range", ev_drop6, 0);
        frame_trig6 = 1'b1;
        step();
        frame_trig6 = 1'b0;
        row_ready6 = 1'b1;
        for (int r = 0; r < 6; r++) begin
            chk("row6_valid", row_valid6, 1);
            chk("row6_idx", row_idx6, r);
            chk("row6_data", row_data6, (r == 5) ? 16'h0020 : 16'h0000);
            chk("row6_miss", trig_miss6, 0);
            step();
        end
        row_ready6 = 1'b0;
        chk("frame6_done", frame_done6, 1);
        chk("frame6_row_valid", row_valid6, 0);
        chk("frame6_ev_ready", ev_ready6, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
